// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-BRAM arbiter and its read tracker.
package mem_pkg;

  // Must match the data BRAM instance geometry.
  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;

  // Which requester a read in flight belongs to.
  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_e;

  // Arbitration priority state.
  typedef enum logic {
    CORE_PRI = 1'b0,
    DBG_PRI  = 1'b1
  } prio_e;

  // One stage of the read-latency pipeline.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/mem_rd_track.sv
// Read-latency tracker: follows each granted read through the BRAM latency
// and steers douta into the owning port's read-data register.
module mem_rd_track
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              issue,
  input  owner_e            issue_owner,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              busy
);

  rd_tag_t pipe [RD_LAT];
  rd_tag_t last;

  assign last = pipe[RD_LAT-1];

  // Shift the {valid, owner} tag one stage per cycle; reset drops reads in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: issue, owner: issue_owner};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Capture douta when the oldest tag is valid and pulse the owner's rvalid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      core_rvalid <= 1'b0;
      dbg_rvalid  <= 1'b0;
      core_rdata  <= '0;
      dbg_rdata   <= '0;
    end else begin
      core_rvalid <= last.valid && (last.owner == OWN_CORE);
      dbg_rvalid  <= last.valid && (last.owner == OWN_DBG);
      if (last.valid && (last.owner == OWN_CORE)) core_rdata <= bram_dout;
      if (last.valid && (last.owner == OWN_DBG))  dbg_rdata  <= bram_dout;
    end
  end

  // Busy while any stage still carries a read.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) busy = busy | pipe[i].valid;
  end

endmodule

// File: rtl/mem_arb.sv
// Two-port arbiter for the single-port data BRAM (core load/store vs. debug
// loader), with a starvation guard that forces a debug grant periodically.
//
// Handshake: a requester raises req with we/addr/wdata stable and holds them
// until gnt. gnt is combinational; the access reaches the BRAM in the same
// cycle, and the requester may drop req or present the next request in the
// following cycle. Reads return one rvalid pulse RD_LAT+1 cycles after gnt.
module mem_arb
  import mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(STARVE_MAX);

  prio_e            prio_state, prio_next;
  logic [CNT_W-1:0] starve_cnt, starve_next;
  logic             rd_issue;
  owner_e           rd_owner;

  // Grant: lone requester wins; on conflict the priority state decides.
  always_comb begin
    core_gnt = core_req && !(dbg_req && (prio_state == DBG_PRI));
    dbg_gnt  = dbg_req && (!core_req || (prio_state == DBG_PRI));
  end

  // BRAM port mux: winner's access, or an all-zero idle cycle.
  always_comb begin
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    rd_issue  = 1'b0;
    rd_owner  = OWN_CORE;
    if (core_gnt) begin
      bram_we   = core_we;
      bram_addr = core_addr;
      bram_din  = core_wdata;
      rd_issue  = !core_we;
    end else if (dbg_gnt) begin
      bram_we   = dbg_we;
      bram_addr = dbg_addr;
      bram_din  = dbg_wdata;
      rd_issue  = !dbg_we;
      rd_owner  = OWN_DBG;
    end
  end

  // Priority state and starvation counter registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prio_state <= CORE_PRI;
      starve_cnt <= '0;
    end else begin
      prio_state <= prio_next;
      starve_cnt <= starve_next;
    end
  end

  // Count core wins over a waiting debug port; after STARVE_MAX of them debug
  // gets exactly one turn (or the turn lapses if debug stops asking).
  always_comb begin
    prio_next   = prio_state;
    starve_next = starve_cnt;
    case (prio_state)
      CORE_PRI: begin
        if (!dbg_req || dbg_gnt) begin
          starve_next = '0;
        end else if (core_gnt) begin
          if (starve_cnt != STARVE_CNT) starve_next = starve_cnt + CNT_W'(1);
          if (starve_next == STARVE_CNT) prio_next = DBG_PRI;
        end
      end
      DBG_PRI: begin
        prio_next   = CORE_PRI;
        starve_next = '0;
      end
      default: begin
        prio_next   = CORE_PRI;
        starve_next = '0;
      end
    endcase
  end

  mem_rd_track #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_track (
    .clk         (clk),
    .rstn        (rstn),
    .issue       (rd_issue),
    .issue_owner (rd_owner),
    .bram_dout   (bram_dout),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .dbg_rvalid  (dbg_rvalid),
    .dbg_rdata   (dbg_rdata),
    .busy        (busy)
  );

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: BRAM model, queue-fed requester drivers, a cycle-level
// reference model of grants/returns, directed scenarios and a random phase.
module tb_mem_arb;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int RD_LAT = 2;
  localparam int STARVE_MAX = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- DUT ----------------
  logic          core_req, core_we, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din, bram_dout;
  logic          bram_we, busy;

  mem_arb #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rstn(rstn),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .bram_dout(bram_dout), .busy(busy)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- BRAM model (RD_LAT registered read) ----------------
  logic [DW-1:0] bram_mem [int];
  logic [DW-1:0] bram_pipe [RD_LAT];
  logic          cap_we = 1'b0;
  logic [AW-1:0] cap_addr = '0;
  logic [DW-1:0] cap_din = '0;
  assign bram_dout = bram_pipe[RD_LAT-1];

  initial forever begin
    @(posedge clk);
    bram_pipe[0] <= bram_mem.exists(int'(cap_addr)) ? bram_mem[int'(cap_addr)] : '0;
    for (int i = 1; i < RD_LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
    if (cap_we) bram_mem[int'(cap_addr)] = cap_din;
  end

  // ---------------- drivers (hold request until granted) ----------------
  req_t core_pend[$];
  req_t dbg_pend[$];
  logic core_took = 1'b0;
  logic dbg_took = 1'b0;

  function automatic req_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.we = we; r.addr = a; r.data = d;
    return r;
  endfunction

  function automatic req_t rand_req();
    logic [AW-1:0] a;
    a = ($urandom_range(0, 7) == 0) ? 15'h7FFF : AW'($urandom_range(0, 15));
    return mk(1'($urandom_range(0, 1)), a, $urandom);
  endfunction

  initial begin
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (core_took && core_pend.size() > 0) void'(core_pend.pop_front());
      if (dbg_took && dbg_pend.size() > 0) void'(dbg_pend.pop_front());
      if (core_pend.size() > 0) begin
        core_req = 1'b1; core_we = core_pend[0].we;
        core_addr = core_pend[0].addr; core_wdata = core_pend[0].data;
      end else begin
        core_req = 1'b0; core_we = 1'($urandom);
        core_addr = AW'($urandom); core_wdata = $urandom;
      end
      if (dbg_pend.size() > 0) begin
        dbg_req = 1'b1; dbg_we = dbg_pend[0].we;
        dbg_addr = dbg_pend[0].addr; dbg_wdata = dbg_pend[0].data;
      end else begin
        dbg_req = 1'b0; dbg_we = 1'($urandom);
        dbg_addr = AW'($urandom); dbg_wdata = $urandom;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] core_exp_q[$];
  logic [DW-1:0] dbg_exp_q[$];
  int            core_due_q[$];
  int            dbg_due_q[$];
  int            rd_grant_q[$];
  int            dbg_gnt_cyc_q[$];
  int            streak = 0;
  logic [DW-1:0] core_rdata_exp = '0;
  logic [DW-1:0] dbg_rdata_exp = '0;

  initial forever begin
    logic ecg, edg, forced, w, erv;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    forced = (streak >= STARVE_MAX);
    ecg = core_req && !(dbg_req && forced);
    edg = dbg_req && (!core_req || forced);
    check("core_gnt", core_gnt, ecg);
    check("dbg_gnt", dbg_gnt, edg);
    w = 1'b0; a = '0; d = '0;
    if (ecg) begin w = core_we; a = core_addr; d = core_wdata; end
    else if (edg) begin w = dbg_we; a = dbg_addr; d = dbg_wdata; end
    check("bram_we", bram_we, w);
    check("bram_addr", bram_addr, a);
    check("bram_din", bram_din, d);

    while (rd_grant_q.size() > 0 && cyc - rd_grant_q[0] > RD_LAT) void'(rd_grant_q.pop_front());
    check("busy", busy, rd_grant_q.size() > 0);

    erv = core_due_q.size() > 0 && core_due_q[0] == cyc;
    check("core_rvalid", core_rvalid, erv);
    if (erv) begin
      core_rdata_exp = core_exp_q.pop_front();
      void'(core_due_q.pop_front());
    end
    check("core_rdata", core_rdata, core_rdata_exp);
    erv = dbg_due_q.size() > 0 && dbg_due_q[0] == cyc;
    check("dbg_rvalid", dbg_rvalid, erv);
    if (erv) begin
      dbg_rdata_exp = dbg_exp_q.pop_front();
      void'(dbg_due_q.pop_front());
    end
    check("dbg_rdata", dbg_rdata, dbg_rdata_exp);

    if (ecg || edg) begin
      if (w) ref_mem[int'(a)] = d;
      else begin
        d = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
        if (ecg) begin core_exp_q.push_back(d); core_due_q.push_back(cyc + RD_LAT + 1); end
        else begin dbg_exp_q.push_back(d); dbg_due_q.push_back(cyc + RD_LAT + 1); end
        rd_grant_q.push_back(cyc);
      end
    end
    if (edg) dbg_gnt_cyc_q.push_back(cyc);
    streak = (ecg && dbg_req) ? ((streak < STARVE_MAX) ? streak + 1 : streak) : 0;

    core_took = core_gnt; dbg_took = dbg_gnt;
    cap_we = bram_we; cap_addr = bram_addr; cap_din = bram_din;

    if (!rstn) begin
      core_exp_q.delete(); dbg_exp_q.delete();
      core_due_q.delete(); dbg_due_q.delete(); rd_grant_q.delete();
      core_rdata_exp = '0; dbg_rdata_exp = '0; streak = 0;
    end
  end

  task automatic wait_idle(input int bound);
    int n = 0;
    int pending;
    do begin
      @(negedge clk); #2; n++;
      pending = core_pend.size() + dbg_pend.size() + core_due_q.size() + dbg_due_q.size();
    end while (pending != 0 && n < bound);
    check("idle_timeout", pending, 0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int start;
    int n;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // core write then read of the same word
    @(negedge clk);
    core_pend.push_back(mk(1'b1, 15'd5, 32'h0000_1234));
    core_pend.push_back(mk(1'b0, 15'd5, '0));
    wait_idle(50);
    check("t1_core_rdata", core_rdata, 32'h0000_1234);

    // simultaneous reads: core first, debug one cycle later
    @(negedge clk);
    core_pend.push_back(mk(1'b1, 15'd1, 32'hA));
    core_pend.push_back(mk(1'b1, 15'd2, 32'hB));
    wait_idle(50);
    @(negedge clk);
    core_pend.push_back(mk(1'b0, 15'd1, '0));
    dbg_pend.push_back(mk(1'b0, 15'd2, '0));
    wait_idle(50);
    check("t2_core_rdata", core_rdata, 32'hA);
    check("t2_dbg_rdata", dbg_rdata, 32'hB);

    // starvation guard: one debug grant every STARVE_MAX+1 cycles
    @(negedge clk);
    dbg_gnt_cyc_q.delete();
    start = cyc;
    for (int i = 0; i < 40; i++) core_pend.push_back(mk(1'b0, AW'($urandom_range(0, 15)), '0));
    for (int i = 0; i < 4; i++) dbg_pend.push_back(mk(1'b0, AW'(i), '0));
    wait_idle(200);
    check("t3_dbg_gnt_count", dbg_gnt_cyc_q.size(), 4);
    if (dbg_gnt_cyc_q.size() == 4) begin
      check("t3_first_dbg_gnt", dbg_gnt_cyc_q[0] - start, STARVE_MAX + 1);
      for (int i = 1; i < 4; i++)
        check("t3_dbg_gnt_gap", dbg_gnt_cyc_q[i] - dbg_gnt_cyc_q[i-1], STARVE_MAX + 1);
    end

    // debug write then read at the top address, back to back
    @(negedge clk);
    dbg_pend.push_back(mk(1'b1, 15'h7FFF, 32'hDEAD_BEEF));
    dbg_pend.push_back(mk(1'b0, 15'h7FFF, '0));
    wait_idle(50);
    check("t4_dbg_rdata", dbg_rdata, 32'hDEAD_BEEF);

    // reset while a core read is in flight
    @(negedge clk);
    core_pend.push_back(mk(1'b0, 15'd5, '0));
    n = 0;
    do begin @(negedge clk); #2; n++; end while (!core_took && n < 20);
    check("t5_grant_seen", core_took, 1'b1);
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    check("t5_busy", busy, 1'b0);
    check("t5_core_rdata", core_rdata, '0);

    // debug held while core has priority; bram_addr follows the winner only
    @(negedge clk);
    for (int i = 0; i < 6; i++) core_pend.push_back(mk(1'b0, AW'(i), '0));
    dbg_pend.push_back(mk(1'b0, 15'h7FFF, '0));
    wait_idle(50);

    // random mix
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (core_pend.size() < 2 && $urandom_range(0, 2) == 0) core_pend.push_back(rand_req());
      if (dbg_pend.size() < 2 && $urandom_range(0, 2) == 0) dbg_pend.push_back(rand_req());
    end
    wait_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
Two-requester arbiter for the single-port data BRAM. It shares the BRAM between the core load/store path and the debug/loader path, which the UART loader uses to preload and dump data memory. It issues at most one access per cycle, tracks read latency, and returns read data to the originating port. A starvation guard ensures the debug port makes progress while the core is saturating the BRAM.

Parameters:
ADDR_W, 15, BRAM word-address width
DATA_W, 32, data width
RD_LAT, 2, BRAM cycles from address-sampling edge to valid douta (must be ≥1)
STARVE_MAX, 8, consecutive core grants with debug pending before debug is forced

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
core_req  in  1  core access request; fields held until core_gnt
core_we  in  1  1 = write, 0 = read
core_addr  in  ADDR_W  word address
core_wdata  in  DATA_W  write data
core_gnt  out  1  request accepted this cycle
core_rvalid  out  1  one-cycle pulse, core_rdata valid
core_rdata  out  DATA_W  registered read data, held between pulses
dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug request, same semantics as core
dbg_gnt  out  1  debug request accepted
dbg_rvalid  out  1  debug read-data pulse
dbg_rdata  out  DATA_W  registered debug read data
bram_addr  out  ADDR_W  to BRAM addra
bram_din  out  DATA_W  to BRAM dina
bram_we  out  1  to BRAM wea
bram_dout  in  DATA_W  from BRAM douta
busy  out  1  a read is in flight

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state = CORE_PRI, starvation counter = 0, in-flight pipeline cleared.
  - core_rvalid = dbg_rvalid = 0; core_rdata = dbg_rdata = 0; busy = 0.
  - Reads in flight at reset are discarded, and no rvalid is produced for them after reset.
- Handshake:
  - Requester asserts req with we/addr/wdata stable.
  - gnt is combinational and is asserted in cycle N when that port wins.
  - The access is presented to the BRAM in cycle N.
  - Requester may drop req or present a new request in N+1.
  - req without gnt holds; it is never dropped by the arbiter.
- Grant rules: at most one gnt per cycle.
  - Only one port requesting → that port is granted.
  - Both requesting → the priority state decides.
  - Back-to-back grants every cycle are permitted. No bubble is inserted between a write and a following read.
- BRAM drive:
  - Granted cycle: bram_addr/bram_din = winner's addr/wdata; bram_we = winner's we.
  - No grant: bram_we = 0, bram_addr = 0, bram_din = 0.
- Read return:
  - A read granted in cycle N has douta sampled at the end of cycle N+RD_LAT.
  - The owner's rdata register loads then; owner's rvalid = 1 in cycle N+RD_LAT+1 for exactly one cycle.
  - Total latency = RD_LAT+1 cycles.
  - Implemented as a RD_LAT-deep shift register of {valid, owner}.
  - Returns are strictly in grant order. Writes produce no rvalid.
- Ordering: a read granted in the cycle after a write to the same address returns the new data, because BRAM order is preserved.
- busy: high while any pipeline stage holds a valid read.
- Priority FSM:
  - CORE_PRI: core wins conflicts.
    - Each cycle core is granted while dbg_req=1, the counter increments.
    - When the counter reaches STARVE_MAX → DBG_PRI.
    - The counter clears on any cycle dbg_req=0 or dbg is granted.
  - DBG_PRI: debug wins the next conflict or lone debug request. After that single debug grant → CORE_PRI, counter = 0.
  - DBG_PRI with dbg_req dropped → CORE_PRI next cycle.
- Widths: counter width is $clog2(STARVE_MAX+1); it saturates and never wraps.

Decomposition:
- Shared package (mem_pkg), holds:
  - owner enum {OWN_CORE, OWN_DBG}
  - priority-state enum {CORE_PRI, DBG_PRI}
  - default ADDR_W/DATA_W constants, which must match the BRAM instance (15/32)
- One sub-module: mem_rd_track, the RD_LAT-deep {valid, owner} pipeline plus the two rdata/rvalid output registers, cleared on reset.
- mem_arb holds the grant logic, the FSM and the BRAM mux.

Test Plan:
- Core-only read: core write 0x00001234 to addr 5, then core read addr 5. Expect core_gnt in both cycles and core_rvalid exactly 3 cycles after the read grant (RD_LAT=2), with core_rdata=0x00001234. dbg_rvalid stays 0.
- Simultaneous requests:
  - Stimulus: core reads addr 1 (holds 0xA) and dbg reads addr 2 (holds 0xB), both in cycle 0.
  - Grants: core_gnt in cycle 0, dbg_gnt in cycle 1.
  - Returns: core_rvalid in cycle 3 with data 0xA; dbg_rvalid in cycle 4 with data 0xB.
- Starvation: core_req held high continuously and dbg_req held high. Expect 8 consecutive core grants, then exactly 1 dbg_gnt, then core resumes. The pattern repeats every 9 cycles.
- Back-to-back write/read: dbg write 0xDEADBEEF to addr 0x7FFF in cycle 0, dbg read addr 0x7FFF in cycle 1. Expect dbg_rdata=0xDEADBEEF with dbg_rvalid in cycle 4. No write-induced rvalid.
- Reset mid-flight: core read granted in cycle 0, rstn=0 in cycle 1. Expect no core_rvalid in cycles 2-5, busy=0, and rdata=0 after reset.
- Hold semantics: dbg_req held for 5 cycles under core priority with core_req high. Check dbg_addr is sampled only in the dbg_gnt cycle (bram_addr equals dbg_addr only then), and that bram_we is 0 in all idle cycles.
